// File: rtl/hack_cpu_pkg.sv
// Shared constants, decoded-control struct and instruction decoder for the Hack CPU.
package hack_cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int AWIDTH = 15;

  localparam int INSTR_C = 15;
  localparam int INSTR_A = 12;
  localparam int CTRL_HI = 11;
  localparam int CTRL_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JLT     = 2;
  localparam int JEQ     = 1;
  localparam int JGT     = 0;

  typedef struct packed {
    logic       is_c;
    logic       sel_m;
    logic [5:0] alu_op;   // {zx, nx, zy, ny, f, no}
    logic       dst_a;
    logic       dst_d;
    logic       dst_m;
    logic       jlt;
    logic       jeq;
    logic       jgt;
  } ctrl_t;

  // Destination and jump bits are masked for A-instructions so they cannot fire.
  function automatic ctrl_t decode(input logic [WIDTH-1:0] instr);
    ctrl_t c;
    c.is_c   = instr[INSTR_C];
    c.sel_m  = instr[INSTR_A];
    c.alu_op = instr[CTRL_HI:CTRL_LO];
    c.dst_a  = instr[INSTR_C] & instr[DEST_A];
    c.dst_d  = instr[INSTR_C] & instr[DEST_D];
    c.dst_m  = instr[INSTR_C] & instr[DEST_M];
    c.jlt    = instr[INSTR_C] & instr[JLT];
    c.jeq    = instr[INSTR_C] & instr[JEQ];
    c.jgt    = instr[INSTR_C] & instr[JGT];
    return c;
  endfunction

endpackage

// File: rtl/alu.sv
// Hack ALU: optional zero/negate on each operand, add or and, optional negate of result.
import hack_cpu_pkg::*;

module alu (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);
  logic [WIDTH-1:0] x0, x1, y0, y1, r;

  always_comb begin
    x0    = zx_i ? '0 : x_i;
    x1    = nx_i ? ~x0 : x0;
    y0    = zy_i ? '0 : y_i;
    y1    = ny_i ? ~y0 : y0;
    r     = f_i ? (x1 + y1) : (x1 & y1);
    out_o = no_i ? ~r : r;
  end

  assign zr_o = (out_o == '0);
  assign ng_o = out_o[WIDTH-1];
endmodule

// File: rtl/hack_cpu_pc_counter.sv
// Program counter: synchronous reset, then load, then increment (wraps mod 2^AWIDTH).
import hack_cpu_pkg::*;

module pc_counter (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [AWIDTH-1:0] din_i,
  output logic [AWIDTH-1:0] pc_o
);
  logic [AWIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q + 1'b1;
    if (load_i) pc_d = din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/mux_16.sv
// 16-bit two-way selector: sel_i=1 picks b_i.
import hack_cpu_pkg::*;

module mux_16 (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: A/D registers, decode, ALU hookup, jump logic and PC.
import hack_cpu_pkg::*;

module hack_cpu (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic [WIDTH-1:0]  inM,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic [AWIDTH-1:0] addressM,
  output logic [AWIDTH-1:0] pc
);
  ctrl_t            ctrl;
  logic [WIDTH-1:0] a_q, a_d, d_q, d_d;
  logic [WIDTH-1:0] y_sel, alu_out;
  logic             zr, ng, jump;
  logic             unused_ok;

  assign ctrl      = decode(instruction);
  assign unused_ok = ^instruction[14:13];

  mux_16 u_ymux (
    .a_i   (a_q),
    .b_i   (inM),
    .sel_i (ctrl.sel_m),
    .y_o   (y_sel)
  );

  alu u_alu (
    .x_i   (d_q),
    .y_i   (y_sel),
    .zx_i  (ctrl.alu_op[5]),
    .nx_i  (ctrl.alu_op[4]),
    .zy_i  (ctrl.alu_op[3]),
    .ny_i  (ctrl.alu_op[2]),
    .f_i   (ctrl.alu_op[1]),
    .no_i  (ctrl.alu_op[0]),
    .out_o (alu_out),
    .zr_o  (zr),
    .ng_o  (ng)
  );

  assign jump = (ctrl.jlt & ng) | (ctrl.jeq & zr) | (ctrl.jgt & ~zr & ~ng);

  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (!ctrl.is_c)     a_d = {1'b0, instruction[AWIDTH-1:0]};
    else if (ctrl.dst_a) a_d = alu_out;
    if (ctrl.dst_d)     d_d = alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Jump target is the pre-edge A, even when the same instruction rewrites A.
  pc_counter u_pc (
    .clk    (clk),
    .reset  (reset),
    .load_i (jump),
    .din_i  (a_q[AWIDTH-1:0]),
    .pc_o   (pc)
  );

  assign outM     = alu_out;
  assign addressM = a_q[AWIDTH-1:0];
  assign writeM   = ctrl.dst_m & ~reset;
endmodule

// File: tb/tb_hack_cpu.sv
// Directed table-driven bench for hack_cpu; observes D through outM with comp=D instructions.
module tb_hack_cpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int n_chk  = 0;
  int n_fail = 0;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic [15:0] m_in;
    bit          c_out;
    logic [15:0] e_out;
    logic        e_wr;
    bit          c_addr;
    logic [14:0] e_addr;
    logic [14:0] e_pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [15:0] i, input logic [15:0] m,
                     input bit co, input logic [15:0] eo, input logic ew,
                     input bit ca, input logic [14:0] ea, input logic [14:0] ep);
    vec_t v;
    v.rst = r; v.instr = i; v.m_in = m; v.c_out = co; v.e_out = eo; v.e_wr = ew;
    v.c_addr = ca; v.e_addr = ea; v.e_pc = ep;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    reset = v.rst; instruction = v.instr; inM = v.m_in;
    @(negedge clk);
    chk("writeM", idx, {15'b0, writeM}, {15'b0, v.e_wr});
    if (v.c_out)  chk("outM", idx, outM, v.e_out);
    if (v.c_addr) chk("addressM", idx, {1'b0, addressM}, {1'b0, v.e_addr});
    @(posedge clk); #1;
    chk("pc", idx, {1'b0, pc}, {1'b0, v.e_pc});
  endtask

  initial begin
    reset = 1'b1; instruction = 16'h0000; inM = 16'h0000;
    @(posedge clk); #1;

    //   rst  instr     inM      chkO eOut     eW  chkA eAddr    ePc
    add(1, 16'hE32F, 16'h0000, 0, 16'h0000, 0, 0, 15'h0000, 15'h0000); // reset beats M-write+jump
    add(0, 16'hE300, 16'h0000, 1, 16'h0000, 0, 1, 15'h0000, 15'h0001); // D==0
    add(0, 16'h0015, 16'h0000, 0, 16'h0000, 0, 1, 15'h0000, 15'h0002);
    add(0, 16'hEC10, 16'h0000, 1, 16'h0015, 0, 1, 15'h0015, 15'h0003); // D=A
    add(0, 16'h0064, 16'h0000, 0, 16'h0000, 0, 1, 15'h0015, 15'h0004);
    add(0, 16'hE7C8, 16'h0000, 1, 16'h0016, 1, 1, 15'h0064, 15'h0005); // M=D+1
    add(0, 16'hE300, 16'h0000, 1, 16'h0015, 0, 1, 15'h0064, 15'h0006); // D, A kept
    add(0, 16'h0032, 16'h0000, 0, 16'h0000, 0, 1, 15'h0064, 15'h0007);
    add(0, 16'hFC10, 16'h8000, 1, 16'h8000, 0, 1, 15'h0032, 15'h0008); // D=M
    add(0, 16'hE304, 16'h0000, 1, 16'h8000, 0, 1, 15'h0032, 15'h0032); // D;JLT taken
    add(0, 16'h0005, 16'h0000, 0, 16'h0000, 0, 1, 15'h0032, 15'h0033);
    add(0, 16'hEC10, 16'h0000, 1, 16'h0005, 0, 1, 15'h0005, 15'h0034);
    add(0, 16'hE302, 16'h0000, 1, 16'h0005, 0, 1, 15'h0005, 15'h0035); // D;JEQ not taken
    add(0, 16'h0007, 16'h0000, 0, 16'h0000, 0, 1, 15'h0005, 15'h0036);
    add(0, 16'hEA87, 16'h0000, 1, 16'h0000, 0, 1, 15'h0007, 15'h0007); // 0;JMP
    add(0, 16'h7FFF, 16'h0000, 0, 16'h0000, 0, 1, 15'h0007, 15'h0008);
    add(0, 16'hEA87, 16'h0000, 1, 16'h0000, 0, 1, 15'h7FFF, 15'h7FFF);
    add(0, 16'h0003, 16'h0000, 0, 16'h0000, 0, 1, 15'h7FFF, 15'h0000); // pc wraps
    add(0, 16'hEC10, 16'h0000, 1, 16'h0003, 0, 1, 15'h0003, 15'h0001);
    add(0, 16'h0009, 16'h0000, 0, 16'h0000, 0, 1, 15'h0003, 15'h0002);
    add(0, 16'hE32F, 16'h0000, 1, 16'h0003, 1, 1, 15'h0009, 15'h0009); // AM=D;JMP, old A used
    add(0, 16'hEC00, 16'h0000, 1, 16'h0003, 0, 1, 15'h0003, 15'h000A); // A now 3
    add(1, 16'hE7C8, 16'h0000, 0, 16'h0000, 0, 0, 15'h0000, 15'h0000); // mid-program reset
    add(0, 16'hE300, 16'h0000, 1, 16'h0000, 0, 1, 15'h0000, 15'h0001);
    add(0, 16'hE7D0, 16'h0000, 1, 16'h0001, 0, 1, 15'h0000, 15'h0002); // D=D+1 uses old D
    add(0, 16'hE300, 16'h0000, 1, 16'h0001, 0, 1, 15'h0000, 15'h0003);
    add(0, 16'hE301, 16'h0000, 1, 16'h0001, 0, 1, 15'h0000, 15'h0000); // D;JGT taken to A=0

    foreach (tv[i]) run(tv[i], i);

    // Reset held across several cycles carrying a write+jump: pc pinned to 0, no write.
    instruction = 16'h0123; reset = 1'b0;
    @(posedge clk); #1;
    chk("seq_pc_pre", 100, {1'b0, pc}, 16'h0001);
    instruction = 16'hEA8F; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("seq_wr_rst", 101 + k, {15'b0, writeM}, 16'h0000);
      @(posedge clk); #1;
      chk("seq_pc_rst", 101 + k, {1'b0, pc}, 16'h0000);
    end
    reset = 1'b0; instruction = 16'hEC00;
    @(negedge clk);
    chk("seq_a_cleared", 110, outM, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
